mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencing controller for the core's single memory port. It shares that port between the instruction-fetch requester and the load/store (data) requester, with round-robin arbitration and one outstanding access at a time. Each granted access is presented to the memory for a fixed latency, and read data plus error flags are returned to the requester that owns the access. It sits between the Argon core's fetch/LSU logic and the `Memory` instance.

## Interface
Parameters:
- `MEM_LATENCY`, 1: cycles from command presentation to valid `i_mem_rd_data`; legal range 1–7.
- `FETCH_RD_MASK`, 3'b111: read-mask encoding driven for every fetch (full word).

Ports:
- `i_clk`  in  1  single clock.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_halt`  in  1  blocks new grants; an access already in flight completes.
- `i_f_req`  in  1  fetch request.
- `i_f_addr`  in  32  fetch address.
- `o_f_gnt`  out  1  fetch request accepted this cycle.
- `o_f_rvalid`  out  1  one-cycle fetch response strobe.
- `o_f_rdata`  out  32  fetch read data, valid with `o_f_rvalid`.
- `o_f_err`  out  2  {misaligned, invalid_read_mask}, valid with `o_f_rvalid`.
- `i_d_req`  in  1  data request.
- `i_d_addr`  in  32  data address.
- `i_d_wdata`  in  32  store data.
- `i_d_wr_mask`  in  2  write mask; 0 means no write.
- `i_d_rd_mask`  in  3  read mask; 0 means no read.
- `o_d_gnt`  out  1  data request accepted this cycle.
- `o_d_rvalid`  out  1  one-cycle data completion strobe, issued for loads and stores.
- `o_d_rdata`  out  32  load data; 0 for a store-only access.
- `o_d_err`  out  2  {misaligned, invalid_read_mask}.
- `o_mem_addr`  out  32; `o_mem_wr_data`  out  32; `o_mem_wr_mask`  out  2; `o_mem_rd_mask`  out  3: memory command.
- `i_mem_rd_data`  in  32; `i_mem_err_misaligned`  in  1; `i_mem_err_invalid_rd_mask`  in  1: memory response.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:** if `i_halt` is 0 and a request is present, grant exactly one requester, latch its command into `cmd_q` along with the owner id, and go to ACCESS.
- **ACCESS:** drive `cmd_q` onto the `o_mem_*` outputs. Load the latency counter with `MEM_LATENCY-1` on entry and decrement it each cycle. When the counter reaches 0, go to RESP.
- **RESP:** pulse the owner's `rvalid`. Pass `i_mem_rd_data` through as `rdata`, or drive 0 if the command's rd_mask was 0. Present the latched error flags. Return to IDLE.
- **Arbitration:**
  - A single requester is granted immediately.
  - When both request, grant the one not granted last.
  - `last_gnt` resets to FETCH, so the first tie goes to DATA.
- **Requester rules:**
  - `gnt` is combinational from `req`, asserted only in IDLE.
  - The payload must be stable while `req` is high.
  - `req` may stay high after a grant to queue the next access.
- **Error latching:** error inputs are sampled in the first ACCESS cycle, held in `err_q`, and reported in RESP. Errors do not abort the access.
- **Idle memory outputs:** outside ACCESS, `o_mem_wr_mask` and `o_mem_rd_mask` are 0 and `o_mem_addr`/`o_mem_wr_data` hold their last value. No spurious access is possible.
- **Halt:** `i_halt` asserted during ACCESS or RESP has no effect on that access. The FSM then stays in IDLE with no grants until `i_halt` deasserts.

## Timing
- Accept in cycle T (`req & gnt`). Command on the `o_mem_*` outputs from T+1 through T+MEM_LATENCY. `rvalid` in T+MEM_LATENCY+1.
- Peak throughput is one access per MEM_LATENCY+2 cycles. The next grant can occur at the earliest in the cycle after RESP.
- Reset values:
  - State IDLE, `last_gnt` FETCH, counter 0.
  - All `gnt`/`rvalid` outputs 0; `rdata` and `err` 0.
  - `o_mem_*` all 0.
- **Reset mid-access:** the FSM returns to IDLE immediately, masks go to 0, and the in-flight access is dropped with no `rvalid`.
- **Requests during ACCESS/RESP:** no `gnt` is issued; the request waits.
- **Simultaneous events:** a grant and a response never occur in the same cycle.

## Structure
- Package `argon_mem_pkg`:
  - `state_t` enum {IDLE, ACCESS, RESP}.
  - `owner_t` enum {OWN_FETCH, OWN_DATA}.
  - `mem_cmd_t` struct {addr, wdata, wr_mask, rd_mask}.
  - Width constants: ADDR_W=32, WR_MASK_W=2, RD_MASK_W=3.
- One sub-module, `rr_arb2`: a two-way round-robin picker with inputs req[1:0], last, and enable, and outputs gnt[1:0]. It is purely combinational; the `last_gnt` register lives in the parent.

## Test plan
- Fetch only, `i_f_addr`=0x100, MEM_LATENCY=1: `o_f_gnt` in T, `o_mem_rd_mask`=3'b111 and `o_mem_addr`=0x100 in T+1, `o_f_rvalid` in T+2 with `o_f_rdata`=mem[0x100].
- Both requesting continuously from reset: grants alternate DATA, FETCH, DATA, FETCH, one every 3 cycles; no cycle has two grants.
- Store 0xDEADBEEF to 0x40 with wr_mask=2'b11, then load from 0x40: the store's `o_d_rvalid` has rdata 0; the load returns 0xDEADBEEF.
- Load from 0x41: `o_d_err`=2'b10 on `o_d_rvalid`, and the FSM returns to IDLE.
- `i_halt` raised in the ACCESS cycle of a fetch: the fetch `rvalid` still occurs; no `gnt` while halted; the pending `i_d_req` is granted the cycle after `i_halt` falls.
- `i_reset_n` pulsed low during ACCESS with MEM_LATENCY=3: masks go to 0 asynchronously, no `rvalid` is ever produced for that access, and the first tie after release grants DATA.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// argon_mem_pkg: shared types and widths for the core's memory-port arbiter.
// Contents:
//   state_t   - sequencing FSM states (IDLE, ACCESS, RESP)
//   owner_t   - which requester owns the access in flight
//   mem_cmd_t - the command latched at grant and driven to the memory
package argon_mem_pkg;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int WR_MASK_W = 2;
  localparam int RD_MASK_W = 3;
  localparam int ERR_W     = 2;
  localparam int CNT_W     = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    wdata;
    logic [WR_MASK_W-1:0] wr_mask;
    logic [RD_MASK_W-1:0] rd_mask;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of the arbiter.
//   Requester side: halt, fetch req/addr/gnt/response, data req/payload/gnt/response.
//   Memory side:    command (addr, wr_data, wr_mask, rd_mask) and response
//                   (rd_data, misaligned, invalid read mask).
// Modports:
//   slave  - the arbiter's view
//   master - the view of whoever drives requests and models the memory
interface mem_port_arbiter_if;
  import argon_mem_pkg::*;

  logic                 i_halt;

  logic                 i_f_req;
  logic [ADDR_W-1:0]    i_f_addr;
  logic                 o_f_gnt;
  logic                 o_f_rvalid;
  logic [DATA_W-1:0]    o_f_rdata;
  logic [ERR_W-1:0]     o_f_err;

  logic                 i_d_req;
  logic [ADDR_W-1:0]    i_d_addr;
  logic [DATA_W-1:0]    i_d_wdata;
  logic [WR_MASK_W-1:0] i_d_wr_mask;
  logic [RD_MASK_W-1:0] i_d_rd_mask;
  logic                 o_d_gnt;
  logic                 o_d_rvalid;
  logic [DATA_W-1:0]    o_d_rdata;
  logic [ERR_W-1:0]     o_d_err;

  logic [ADDR_W-1:0]    o_mem_addr;
  logic [DATA_W-1:0]    o_mem_wr_data;
  logic [WR_MASK_W-1:0] o_mem_wr_mask;
  logic [RD_MASK_W-1:0] o_mem_rd_mask;
  logic [DATA_W-1:0]    i_mem_rd_data;
  logic                 i_mem_err_misaligned;
  logic                 i_mem_err_invalid_rd_mask;

  modport slave (
    input  i_halt,
    input  i_f_req, i_f_addr,
    output o_f_gnt, o_f_rvalid, o_f_rdata, o_f_err,
    input  i_d_req, i_d_addr, i_d_wdata, i_d_wr_mask, i_d_rd_mask,
    output o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err,
    output o_mem_addr, o_mem_wr_data, o_mem_wr_mask, o_mem_rd_mask,
    input  i_mem_rd_data, i_mem_err_misaligned, i_mem_err_invalid_rd_mask
  );

  modport master (
    output i_halt,
    output i_f_req, i_f_addr,
    input  o_f_gnt, o_f_rvalid, o_f_rdata, o_f_err,
    output i_d_req, i_d_addr, i_d_wdata, i_d_wr_mask, i_d_rd_mask,
    input  o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err,
    input  o_mem_addr, o_mem_wr_data, o_mem_wr_mask, o_mem_rd_mask,
    output i_mem_rd_data, i_mem_err_misaligned, i_mem_err_invalid_rd_mask
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   req[1:0] - requests (bit 0 fetch, bit 1 data)
//   last     - 1 if bit 1 won the previous grant
//   enable   - gates all grants
//   gnt[1:0] - one-hot grant (or zero)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       enable,
  output logic [1:0] gnt
);

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between instruction fetch
// and load/store, one outstanding access at a time, round-robin on ties.
// Ports:
//   i_clk, i_reset_n - clock, asynchronous active-low reset
//   bus              - requester handshakes and memory command/response
// Parameters:
//   MEM_LATENCY   - cycles the command is held before read data is valid (1-7)
//   FETCH_RD_MASK - read mask driven for every fetch
module mem_port_arbiter
  import argon_mem_pkg::*;
#(
  parameter int                   MEM_LATENCY   = 1,
  parameter logic [RD_MASK_W-1:0] FETCH_RD_MASK = 3'b111
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t             state;
  state_t             state_next;
  owner_t             owner_q;
  owner_t             last_gnt;
  mem_cmd_t           cmd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ERR_W-1:0]   err_q;
  logic [1:0]         req;
  logic [1:0]         gnt;
  logic               accept;
  logic [DATA_W-1:0]  resp_data;

  assign req    = {bus.i_d_req, bus.i_f_req};
  assign accept = (state == IDLE) && (gnt != 2'b00);

  rr_arb2 u_arb (
    .req    (req),
    .last   (last_gnt == OWN_DATA),
    .enable ((state == IDLE) && !bus.i_halt),
    .gnt    (gnt)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  if (cnt_q == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Fetches leave wdata untouched so o_mem_wr_data keeps its last value.
  // The counter value CNT_LOAD only occurs in the first ACCESS cycle, which
  // is when the memory's error flags are captured.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cmd_q    <= '0;
      owner_q  <= OWN_FETCH;
      last_gnt <= OWN_FETCH;
      cnt_q    <= '0;
      err_q    <= '0;
    end else if (accept) begin
      cnt_q <= CNT_LOAD;
      if (gnt[1]) begin
        owner_q       <= OWN_DATA;
        last_gnt      <= OWN_DATA;
        cmd_q.addr    <= bus.i_d_addr;
        cmd_q.wdata   <= bus.i_d_wdata;
        cmd_q.wr_mask <= bus.i_d_wr_mask;
        cmd_q.rd_mask <= bus.i_d_rd_mask;
      end else begin
        owner_q       <= OWN_FETCH;
        last_gnt      <= OWN_FETCH;
        cmd_q.addr    <= bus.i_f_addr;
        cmd_q.wr_mask <= '0;
        cmd_q.rd_mask <= FETCH_RD_MASK;
      end
    end else if (state == ACCESS) begin
      if (cnt_q == CNT_LOAD) begin
        err_q <= {bus.i_mem_err_misaligned, bus.i_mem_err_invalid_rd_mask};
      end
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Masks are gated by state so the memory sees no access outside ACCESS.
  assign bus.o_f_gnt       = gnt[0];
  assign bus.o_d_gnt       = gnt[1];
  assign bus.o_mem_addr    = cmd_q.addr;
  assign bus.o_mem_wr_data = cmd_q.wdata;
  assign bus.o_mem_wr_mask = (state == ACCESS) ? cmd_q.wr_mask : '0;
  assign bus.o_mem_rd_mask = (state == ACCESS) ? cmd_q.rd_mask : '0;

  assign resp_data      = (cmd_q.rd_mask != '0) ? bus.i_mem_rd_data : '0;
  assign bus.o_f_rvalid = (state == RESP) && (owner_q == OWN_FETCH);
  assign bus.o_d_rvalid = (state == RESP) && (owner_q == OWN_DATA);
  assign bus.o_f_rdata  = bus.o_f_rvalid ? resp_data : '0;
  assign bus.o_d_rdata  = bus.o_d_rvalid ? resp_data : '0;
  assign bus.o_f_err    = bus.o_f_rvalid ? err_q : '0;
  assign bus.o_d_err    = bus.o_d_rvalid ? err_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives fetch/data requests into mem_port_arbiter,
// models the memory behind it, and compares every cycle against a
// transaction-level reference (accept time + fixed latency).
module tb_mem_port_arbiter;
  import argon_mem_pkg::*;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(
    .MEM_LATENCY   (LAT),
    .FETCH_RD_MASK (3'b111)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  function automatic logic [31:0] pattern(input int i);
    return 32'hA500_0000 ^ 32'(i * 32'h0001_0203);
  endfunction

  // Memory device: registered read of the addressed word, full-word writes.
  logic [31:0] dev_mem [256];
  logic [31:0] dev_rd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= pattern(i);
      dev_rd <= 32'h0;
    end else begin
      if (bus.o_mem_wr_mask != 2'b00) dev_mem[bus.o_mem_addr[9:2]] <= bus.o_mem_wr_data;
      dev_rd <= dev_mem[bus.o_mem_addr[9:2]];
    end
  end
  assign bus.i_mem_rd_data = dev_rd;
  assign bus.i_mem_err_misaligned =
    ((bus.o_mem_rd_mask != 3'b000) || (bus.o_mem_wr_mask != 2'b00)) && (bus.o_mem_addr[1:0] != 2'b00);
  assign bus.i_mem_err_invalid_rd_mask = !(bus.o_mem_rd_mask inside {3'b000, 3'b001, 3'b011, 3'b111});

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] ref_mem [256];
  logic        m_busy;
  int          m_age;
  owner_t      m_owner;
  owner_t      m_last;
  logic [31:0] m_addr, m_wdata, m_last_addr, m_exp_rdata;
  logic [1:0]  m_wr, m_exp_err;
  logic [2:0]  m_rd;

  logic        model_gf, model_gd, dut_gf, dut_gd;
  logic        saw_f_rvalid, saw_d_rvalid;
  logic [31:0] cap_f_rdata, cap_d_rdata;
  logic [1:0]  cap_f_err, cap_d_err;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = pattern(i);
    m_busy = 1'b0; m_age = 0; m_owner = OWN_FETCH; m_last = OWN_FETCH;
    m_addr = '0; m_wdata = '0; m_wr = '0; m_rd = '0;
    m_last_addr = '0; m_exp_rdata = '0; m_exp_err = '0;
  endtask

  task automatic model_accept(input logic is_data);
    m_busy = 1'b1; m_age = 1;
    m_owner = is_data ? OWN_DATA : OWN_FETCH;
    m_last = m_owner;
    if (is_data) begin
      m_addr = bus.i_d_addr; m_wdata = bus.i_d_wdata; m_wr = bus.i_d_wr_mask; m_rd = bus.i_d_rd_mask;
    end else begin
      m_addr = bus.i_f_addr; m_wr = 2'b00; m_rd = 3'b111;
    end
    m_last_addr = m_addr;
    m_exp_err[1] = ((m_rd != 3'b000) || (m_wr != 2'b00)) && (m_addr[1:0] != 2'b00);
    m_exp_err[0] = !(m_rd inside {3'b000, 3'b001, 3'b011, 3'b111});
    m_exp_rdata = (m_rd != 3'b000) ? ref_mem[m_addr[9:2]] : 32'h0;
    if (m_wr != 2'b00) ref_mem[m_addr[9:2]] = m_wdata;
  endtask

  // One clock cycle: entered at a negedge with inputs already applied.
  task automatic run_cycle();
    logic eg_f, eg_d, in_acc, in_resp;
    #1;
    eg_f = 1'b0; eg_d = 1'b0;
    if (!m_busy && !bus.i_halt) begin
      if (bus.i_f_req && bus.i_d_req) begin
        if (m_last == OWN_DATA) eg_f = 1'b1; else eg_d = 1'b1;
      end else begin
        eg_f = bus.i_f_req; eg_d = bus.i_d_req;
      end
    end
    in_acc  = m_busy && (m_age <= LAT);
    in_resp = m_busy && (m_age == LAT + 1);
    checkOutput("f_gnt", 32'(bus.o_f_gnt), 32'(eg_f));
    checkOutput("d_gnt", 32'(bus.o_d_gnt), 32'(eg_d));
    checkOutput("mem_rd_mask", 32'(bus.o_mem_rd_mask), in_acc ? 32'(m_rd) : 32'h0);
    checkOutput("mem_wr_mask", 32'(bus.o_mem_wr_mask), in_acc ? 32'(m_wr) : 32'h0);
    checkOutput("mem_addr", bus.o_mem_addr, m_last_addr);
    if (in_acc && m_wr != 2'b00) checkOutput("mem_wr_data", bus.o_mem_wr_data, m_wdata);
    checkOutput("f_rvalid", 32'(bus.o_f_rvalid), 32'(in_resp && m_owner == OWN_FETCH));
    checkOutput("d_rvalid", 32'(bus.o_d_rvalid), 32'(in_resp && m_owner == OWN_DATA));
    if (in_resp && m_owner == OWN_FETCH) begin
      checkOutput("f_rdata", bus.o_f_rdata, m_exp_rdata);
      checkOutput("f_err", 32'(bus.o_f_err), 32'(m_exp_err));
    end
    if (in_resp && m_owner == OWN_DATA) begin
      checkOutput("d_rdata", bus.o_d_rdata, m_exp_rdata);
      checkOutput("d_err", 32'(bus.o_d_err), 32'(m_exp_err));
    end
    dut_gf = bus.o_f_gnt; dut_gd = bus.o_d_gnt;
    if (bus.o_f_rvalid) begin saw_f_rvalid = 1'b1; cap_f_rdata = bus.o_f_rdata; cap_f_err = bus.o_f_err; end
    if (bus.o_d_rvalid) begin saw_d_rvalid = 1'b1; cap_d_rdata = bus.o_d_rdata; cap_d_err = bus.o_d_err; end
    model_gf = eg_f; model_gd = eg_d;
    @(posedge clk);
    if (m_busy) begin
      if (in_resp) m_busy = 1'b0; else m_age++;
    end else if (eg_f || eg_d) begin
      model_accept(eg_d);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [7:0] idx;
    logic [1:0] low;
    idx = 8'($urandom_range(0, 255));
    low = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    return {22'h0, idx, low};
  endfunction

  // Holds a pending request stable; new payload only after a grant or when idle.
  task automatic applyStimulus();
    if (!bus.i_f_req || model_gf) begin
      bus.i_f_req  = ($urandom_range(0, 2) != 0);
      bus.i_f_addr = rand_addr();
    end
    if (!bus.i_d_req || model_gd) begin
      bus.i_d_req  = ($urandom_range(0, 2) != 0);
      bus.i_d_addr = rand_addr();
      if ($urandom_range(0, 1) == 0) begin
        bus.i_d_wr_mask = 2'b11;
        bus.i_d_rd_mask = 3'b000;
        bus.i_d_wdata   = $urandom;
      end else begin
        bus.i_d_wr_mask = 2'b00;
        case ($urandom_range(0, 4))
          0: bus.i_d_rd_mask = 3'b001;
          1: bus.i_d_rd_mask = 3'b011;
          2: bus.i_d_rd_mask = 3'b010;
          default: bus.i_d_rd_mask = 3'b111;
        endcase
        bus.i_d_wdata = 32'h0;
      end
    end
    bus.i_halt = ($urandom_range(0, 15) == 0);
  endtask

  task automatic issue(input logic is_data, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] wr, input logic [2:0] rd);
    logic got;
    got = 1'b0;
    saw_f_rvalid = 1'b0; saw_d_rvalid = 1'b0;
    if (is_data) begin
      bus.i_d_req = 1'b1; bus.i_d_addr = addr; bus.i_d_wdata = wdata;
      bus.i_d_wr_mask = wr; bus.i_d_rd_mask = rd;
    end else begin
      bus.i_f_req = 1'b1; bus.i_f_addr = addr;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      run_cycle();
      got = is_data ? dut_gd : dut_gf;
    end
    checkOutput("grant_seen", 32'(got), 32'h1);
    bus.i_f_req = 1'b0; bus.i_d_req = 1'b0;
    repeat (LAT + 2) run_cycle();
    checkOutput("rvalid_seen", 32'(is_data ? saw_d_rvalid : saw_f_rvalid), 32'h1);
  endtask

  initial begin
    logic order [$];
    logic any_gnt;
    bus.i_halt = 1'b0;
    bus.i_f_req = 1'b0; bus.i_f_addr = '0;
    bus.i_d_req = 1'b0; bus.i_d_addr = '0; bus.i_d_wdata = '0;
    bus.i_d_wr_mask = '0; bus.i_d_rd_mask = '0;
    model_gf = 1'b0; model_gd = 1'b0;
    model_reset();

    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_f_gnt", 32'(bus.o_f_gnt), 32'h0);
    checkOutput("rst_d_gnt", 32'(bus.o_d_gnt), 32'h0);
    checkOutput("rst_f_rvalid", 32'(bus.o_f_rvalid), 32'h0);
    checkOutput("rst_d_rvalid", 32'(bus.o_d_rvalid), 32'h0);
    checkOutput("rst_f_rdata", bus.o_f_rdata, 32'h0);
    checkOutput("rst_d_rdata", bus.o_d_rdata, 32'h0);
    checkOutput("rst_f_err", 32'(bus.o_f_err), 32'h0);
    checkOutput("rst_d_err", 32'(bus.o_d_err), 32'h0);
    checkOutput("rst_mem_addr", bus.o_mem_addr, 32'h0);
    checkOutput("rst_mem_wr_data", bus.o_mem_wr_data, 32'h0);
    checkOutput("rst_mem_wr_mask", 32'(bus.o_mem_wr_mask), 32'h0);
    checkOutput("rst_mem_rd_mask", 32'(bus.o_mem_rd_mask), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    $display("[TB] tie arbitration from reset");
    bus.i_f_req = 1'b1; bus.i_f_addr = 32'h0000_0010;
    bus.i_d_req = 1'b1; bus.i_d_addr = 32'h0000_0020; bus.i_d_rd_mask = 3'b111; bus.i_d_wr_mask = 2'b00;
    repeat (3 * (LAT + 2) + 1) begin
      run_cycle();
      checkOutput("one_grant", 32'(dut_gf && dut_gd), 32'h0);
      if (dut_gd) order.push_back(1'b1);
      if (dut_gf) order.push_back(1'b0);
    end
    checkOutput("tie_count", 32'(order.size() >= 3), 32'h1);
    if (order.size() >= 3) begin
      checkOutput("tie_first_data", 32'(order[0]), 32'h1);
      checkOutput("tie_second_fetch", 32'(order[1]), 32'h0);
      checkOutput("tie_third_data", 32'(order[2]), 32'h1);
    end
    bus.i_f_req = 1'b0; bus.i_d_req = 1'b0;
    repeat (LAT + 2) run_cycle();

    $display("[TB] directed accesses");
    issue(1'b0, 32'h0000_0100, 32'h0, 2'b00, 3'b111);
    checkOutput("fetch_100_rdata", cap_f_rdata, pattern(32'h100 >> 2));
    issue(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 2'b11, 3'b000);
    checkOutput("store_rdata_zero", cap_d_rdata, 32'h0);
    issue(1'b1, 32'h0000_0040, 32'h0, 2'b00, 3'b111);
    checkOutput("load_deadbeef", cap_d_rdata, 32'hDEAD_BEEF);
    issue(1'b1, 32'h0000_0041, 32'h0, 2'b00, 3'b111);
    checkOutput("misaligned_err", 32'(cap_d_err), 32'h2);

    $display("[TB] halt during access");
    bus.i_f_req = 1'b1; bus.i_f_addr = 32'h0000_0080;
    dut_gf = 1'b0;
    for (int i = 0; i < 20 && !dut_gf; i++) run_cycle();
    checkOutput("halt_fetch_gnt", 32'(dut_gf), 32'h1);
    bus.i_f_req = 1'b0;
    bus.i_halt = 1'b1;
    bus.i_d_req = 1'b1; bus.i_d_addr = 32'h0000_0044; bus.i_d_wr_mask = 2'b00; bus.i_d_rd_mask = 3'b111;
    saw_f_rvalid = 1'b0; any_gnt = 1'b0;
    repeat (LAT + 4) begin
      run_cycle();
      any_gnt = any_gnt | dut_gf | dut_gd;
    end
    checkOutput("halt_f_rvalid", 32'(saw_f_rvalid), 32'h1);
    checkOutput("halt_no_gnt", 32'(any_gnt), 32'h0);
    bus.i_halt = 1'b0;
    run_cycle();
    checkOutput("halt_release_gnt", 32'(dut_gd), 32'h1);
    bus.i_d_req = 1'b0;
    repeat (LAT + 2) run_cycle();

    $display("[TB] random traffic");
    model_gf = 1'b0; model_gd = 1'b0;
    repeat (3000) begin
      applyStimulus();
      run_cycle();
    end
    bus.i_f_req = 1'b0; bus.i_d_req = 1'b0; bus.i_halt = 1'b0;
    repeat (LAT + 3) run_cycle();

    $display("[TB] reset during access");
    bus.i_f_req = 1'b1; bus.i_f_addr = 32'h0000_0104;
    dut_gf = 1'b0;
    for (int i = 0; i < 20 && !dut_gf; i++) run_cycle();
    checkOutput("rst_mid_gnt", 32'(dut_gf), 32'h1);
    bus.i_f_req = 1'b0;
    run_cycle();
    checkOutput("rst_mid_pre_mask", 32'(bus.o_mem_rd_mask), 32'h7);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_rd_mask", 32'(bus.o_mem_rd_mask), 32'h0);
    checkOutput("rst_mid_wr_mask", 32'(bus.o_mem_wr_mask), 32'h0);
    checkOutput("rst_mid_f_rvalid", 32'(bus.o_f_rvalid), 32'h0);
    bus.i_f_req = 1'b1; bus.i_f_addr = 32'h0000_0108;
    bus.i_d_req = 1'b1; bus.i_d_addr = 32'h0000_010C; bus.i_d_wr_mask = 2'b00; bus.i_d_rd_mask = 3'b111;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_cycle();
    checkOutput("post_rst_tie_data", 32'(dut_gd), 32'h1);
    bus.i_d_req = 1'b0;
    repeat (2 * (LAT + 2)) run_cycle();
    bus.i_f_req = 1'b0;
    repeat (LAT + 2) run_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
